md5_padder: RTL and testbench

MD5_PADDER -- requirements
Module: md5_padder

---
 rtl/md5_pkg.sv | 15 +
 rtl/md5_len_insert.sv | 17 +
 rtl/md5_padder.sv | 155 +++++++++++++++
 tb/tb_md5_padder.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/md5_pkg.sv
// Shared constants and state encoding for the MD5 message padder.
package md5_pkg;

  localparam int BLOCK_BITS  = 512;
  localparam int BLOCK_BYTES = 64;
  localparam int LEN_OFFSET  = 56;

  typedef enum logic [1:0] {
    ST_ACCEPT = 2'd0,
    ST_EMIT   = 2'd1,
    ST_WAIT   = 2'd2,
    ST_EXTRA  = 2'd3
  } state_t;

endpackage

// File: rtl/md5_len_insert.sv
// Overwrites bytes 56..63 of a block with a 64-bit bit length, LSB first.
module md5_len_insert
  import md5_pkg::*;
(
  input  logic [0:BLOCK_BITS-1] block_in,
  input  logic [63:0]           len_bits,
  output logic [0:BLOCK_BITS-1] block_out
);

  always_comb begin
    block_out = block_in;
    for (int i = 0; i < 8; i++) begin
      block_out[8*(LEN_OFFSET+i) +: 8] = len_bits[8*i +: 8];
    end
  end

endmodule

// File: rtl/md5_padder.sv
// Byte-stream to 512-bit MD5 block padder: appends 0x80, zero fill and the
// little-endian bit length, spilling into an extra block when needed.
module md5_padder
  import md5_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic [0:BLOCK_BITS-1] block,
  output logic                  blk_start,
  output logic                  blk_last,
  input  logic                  core_ready,
  output logic [63:0]           msg_len
);

  state_t                state_q, state_d;
  logic [0:BLOCK_BITS-1] block_q, block_d, block_w, len_src, len_out;
  logic [5:0]            idx_q, idx_d;
  logic [63:0]           cnt_q, cnt_d, cnt_src, len_bits;
  logic [63:0]           msg_len_q, msg_len_d;
  logic                  pad_pending_q, pad_pending_d;
  logic                  need_80_q, need_80_d;
  logic                  blk_start_q, blk_start_d;
  logic                  blk_last_q, blk_last_d;
  logic                  in_ready_q, in_ready_d;

  // Bytes past idx are always zero here, so only the data and marker are written.
  always_comb begin
    block_w = block_q;
    for (int k = 0; k < BLOCK_BYTES; k++) begin
      if (6'(k) == idx_q) begin
        block_w[8*k +: 8] = in_data;
      end else if (in_last && idx_q != 6'd63 && 6'(k) == idx_q + 6'd1) begin
        block_w[8*k +: 8] = 8'h80;
      end
    end
  end

  assign cnt_src  = (state_q == ST_EXTRA) ? cnt_q : cnt_q + 64'd1;
  assign len_bits = cnt_src << 3;

  always_comb begin
    len_src = '0;
    if (state_q == ST_EXTRA) begin
      if (need_80_q) len_src[0:7] = 8'h80;
    end else begin
      len_src = block_w;
    end
  end

  md5_len_insert u_len_insert (
    .block_in  (len_src),
    .len_bits  (len_bits),
    .block_out (len_out)
  );

  always_comb begin
    state_d       = state_q;
    block_d       = block_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    msg_len_d     = msg_len_q;
    pad_pending_d = pad_pending_q;
    need_80_d     = need_80_q;
    blk_start_d   = 1'b0;
    blk_last_d    = blk_last_q;
    case (state_q)
      ST_ACCEPT: begin
        if (in_valid) begin
          block_d = block_w;
          idx_d   = idx_q + 6'd1;
          cnt_d   = cnt_q + 64'd1;
          if (in_last) begin
            state_d     = ST_EMIT;
            blk_start_d = 1'b1;
            if (idx_q <= 6'd54) begin
              block_d    = len_out;
              blk_last_d = 1'b1;
              msg_len_d  = len_bits;
            end else begin
              pad_pending_d = 1'b1;
              need_80_d     = (idx_q == 6'd63);
              blk_last_d    = 1'b0;
            end
          end else if (idx_q == 6'd63) begin
            state_d     = ST_EMIT;
            blk_start_d = 1'b1;
            blk_last_d  = 1'b0;
          end
        end
      end
      ST_EMIT: state_d = ST_WAIT;
      ST_WAIT: begin
        if (core_ready) begin
          if (pad_pending_q) begin
            state_d = ST_EXTRA;
          end else begin
            state_d    = ST_ACCEPT;
            block_d    = '0;
            idx_d      = '0;
            blk_last_d = 1'b0;
            if (blk_last_q) cnt_d = '0;
          end
        end
      end
      ST_EXTRA: begin
        block_d       = len_out;
        blk_last_d    = 1'b1;
        msg_len_d     = len_bits;
        pad_pending_d = 1'b0;
        need_80_d     = 1'b0;
        blk_start_d   = 1'b1;
        state_d       = ST_EMIT;
      end
      default: state_d = ST_ACCEPT;
    endcase
    in_ready_d = (state_d == ST_ACCEPT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_ACCEPT;
      block_q       <= '0;
      idx_q         <= '0;
      cnt_q         <= '0;
      msg_len_q     <= '0;
      pad_pending_q <= 1'b0;
      need_80_q     <= 1'b0;
      blk_start_q   <= 1'b0;
      blk_last_q    <= 1'b0;
      in_ready_q    <= 1'b1;
    end else begin
      state_q       <= state_d;
      block_q       <= block_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      msg_len_q     <= msg_len_d;
      pad_pending_q <= pad_pending_d;
      need_80_q     <= need_80_d;
      blk_start_q   <= blk_start_d;
      blk_last_q    <= blk_last_d;
      in_ready_q    <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign block     = block_q;
  assign blk_start = blk_start_q;
  assign blk_last  = blk_last_q;
  assign msg_len   = msg_len_q;

endmodule

// File: tb/tb_md5_padder.sv
// Directed, table-driven bench for md5_padder with a byte-level padding model.
module tb_md5_padder;

  logic         clk = 1'b0;
  logic         reset;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_last;
  logic         in_ready;
  logic [0:511] block;
  logic         blk_start;
  logic         blk_last;
  logic         core_ready;
  logic [63:0]  msg_len;

  always #5 clk = ~clk;

  md5_padder dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .block      (block),
    .blk_start  (blk_start),
    .blk_last   (blk_last),
    .core_ready (core_ready),
    .msg_len    (msg_len)
  );

  typedef struct {
    int          n;
    logic [7:0]  base;
    logic [7:0]  step;
    int          stall;
    int          exp_blocks;
    logic [63:0] exp_len;
    logic [7:0]  b56;
    logic [7:0]  b57;
  } vec_t;

  vec_t vecs[8];

  int checks = 0;
  int failures = 0;

  logic [0:511] cap_block[$];
  logic         cap_last[$];
  logic [63:0]  cap_len[$];
  int           stall_cycles = 0;
  bit           hold_off = 1'b0;
  bit           pending = 1'b0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Plays the md5 core: captures each block, holds core_ready low for the stall, then acks.
  initial begin : core_model
    int cnt;
    logic [0:511] held;
    cnt = 0;
    held = '0;
    core_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        pending = 1'b0;
        core_ready = 1'b0;
      end else if (blk_start) begin
        cap_block.push_back(block);
        cap_last.push_back(blk_last);
        cap_len.push_back(msg_len);
        held = block;
        pending = 1'b1;
        cnt = stall_cycles;
        core_ready = 1'b0;
      end else if (pending && !hold_off) begin
        if (cnt == 0) begin
          core_ready = 1'b1;
          pending = 1'b0;
        end else begin
          check("wait_block_stable", block, held);
          check("wait_in_ready", in_ready, 1'b0);
          cnt--;
        end
      end else begin
        core_ready = 1'b0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] d, input bit last, output bit ok);
    int guard;
    guard = 0;
    in_data = d;
    in_valid = 1'b1;
    in_last = last;
    ok = 1'b0;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (in_ready) begin
      @(negedge clk);
      ok = 1'b1;
    end
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic clear_capture();
    cap_block.delete();
    cap_last.delete();
    cap_len.delete();
  endtask

  task automatic send_msg(input int n, input logic [7:0] base, input logic [7:0] step,
                          input bit with_last, output bit ok);
    ok = 1'b1;
    for (int i = 0; i < n && ok; i++) begin
      send_byte(8'(base + step * i), with_last && (i == n - 1), ok);
    end
    if (!ok) check("accept_timeout", 1'b0, 1'b1);
  endtask

  task automatic applyStimulus(input vec_t v, input string tag);
    bit ok;
    int guard;
    int nb;
    int last_i;
    logic [7:0] padded[$];
    logic [63:0] bits;
    logic [0:511] exp_blk;
    clear_capture();
    stall_cycles = v.stall;
    send_msg(v.n, v.base, v.step, 1'b1, ok);
    guard = 0;
    while ((cap_block.size() < v.exp_blocks || pending || !in_ready) && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    repeat (3) @(negedge clk);
    check($sformatf("%s_done", tag), guard < 1000, 1'b1);
    check($sformatf("%s_block_count", tag), cap_block.size(), v.exp_blocks);
    // Textbook MD5 padding of the whole message, then sliced into blocks.
    for (int i = 0; i < v.n; i++) padded.push_back(8'(v.base + v.step * i));
    padded.push_back(8'h80);
    while (padded.size() % 64 != 56) padded.push_back(8'h00);
    bits = 64'(v.n) * 64'd8;
    for (int b = 0; b < 8; b++) padded.push_back(bits[8*b +: 8]);
    nb = padded.size() / 64;
    for (int k = 0; k < nb && k < cap_block.size(); k++) begin
      for (int j = 0; j < 64; j++) exp_blk[8*j +: 8] = padded[64*k + j];
      check($sformatf("%s_blk%0d_data", tag, k), cap_block[k], exp_blk);
      check($sformatf("%s_blk%0d_last", tag, k), cap_last[k], k == nb - 1);
    end
    if (cap_block.size() == v.exp_blocks) begin
      last_i = v.exp_blocks - 1;
      check($sformatf("%s_msg_len", tag), cap_len[last_i], v.exp_len);
      check($sformatf("%s_byte56", tag), cap_block[last_i][448 +: 8], v.b56);
      check($sformatf("%s_byte57", tag), cap_block[last_i][456 +: 8], v.b57);
    end
  endtask

  task automatic checkOutput(input string tag);
    check($sformatf("%s_in_ready", tag), in_ready, 1'b1);
    check($sformatf("%s_blk_start", tag), blk_start, 1'b0);
    check($sformatf("%s_blk_last", tag), blk_last, 1'b0);
    check($sformatf("%s_msg_len", tag), msg_len, 64'd0);
    check($sformatf("%s_block", tag), block, 512'd0);
  endtask

  initial begin
    bit ok;
    int guard;
    vec_t abc;
    //           n    base   step  stall blocks len     b56    b57
    vecs[0] = '{   3, 8'h61, 8'h01,  0, 1,  64'd24,  8'h18, 8'h00};
    vecs[1] = '{  55, 8'h61, 8'h00,  0, 1,  64'd440, 8'hB8, 8'h01};
    vecs[2] = '{  56, 8'h61, 8'h00,  0, 2,  64'd448, 8'hC0, 8'h01};
    vecs[3] = '{  64, 8'h00, 8'h01, 10, 2,  64'd512, 8'h00, 8'h02};
    vecs[4] = '{  63, 8'h10, 8'h03,  2, 2,  64'd504, 8'hF8, 8'h01};
    vecs[5] = '{   1, 8'h5A, 8'h00,  1, 1,  64'd8,   8'h08, 8'h00};
    vecs[6] = '{ 120, 8'h20, 8'h07,  3, 3,  64'd960, 8'hC0, 8'h03};
    vecs[7] = '{ 119, 8'hF0, 8'h01,  0, 2,  64'd952, 8'hB8, 8'h03};
    abc = vecs[0];

    reset = 1'b1;
    in_valid = 1'b0;
    in_last = 1'b0;
    in_data = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("reset");

    for (int v = 0; v < 8; v++) applyStimulus(vecs[v], $sformatf("vec%0d", v));

    // Abandon a 20-byte message mid-stream, then "abc" must be the only output.
    clear_capture();
    send_msg(20, 8'h30, 8'h01, 1'b0, ok);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("mid_reset");
    applyStimulus(abc, "after_reset");

    // Reset while a full block waits for the core: nothing more may be emitted.
    clear_capture();
    hold_off = 1'b1;
    send_msg(64, 8'h40, 8'h01, 1'b0, ok);
    guard = 0;
    while (cap_block.size() < 1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    repeat (3) @(negedge clk);
    check("wait_reset_block_seen", cap_block.size(), 1);
    check("wait_reset_stalled", in_ready, 1'b0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    hold_off = 1'b0;
    reset = 1'b0;
    clear_capture();
    repeat (20) @(negedge clk);
    check("wait_reset_no_start", cap_block.size(), 0);
    checkOutput("wait_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
